// File: rtl/alu_mc_if.sv
// alu_mc_if -- operand/result handshake bundle for alu_mc.
//
// Signals:
//   in_valid  : producer presents a, b and op
//   in_ready  : alu can accept a new operation
//   a, b      : operands, WIDTH bits
//   op        : 4-bit operation code
//   out_valid : result c/zero/ovf is held and valid
//   out_ready : consumer takes the result
//   c         : registered result, WIDTH bits
//   zero      : c == 0, registered with c
//   ovf       : signed overflow of ADD/SUB, otherwise 0
//
// Modports: master (producer/consumer side), slave (alu side).
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, c, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, c, zero, ovf
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with valid/ready handshake on both sides.
//
// Single-cycle ops (ADD, SUB, OR, AND, XOR, LUI, SLT, SLL, SRL, SRA and any
// undefined code) load the result at the accept edge; out_valid follows one
// cycle later. MUL (op 1010) runs a shift-add multiplier, one bit per cycle,
// for WIDTH cycles, giving out_valid WIDTH+1 cycles after accept.
//
// Optional feature macro: ALU_MC_MUL_EN. When undefined there is no multiplier,
// BUSY is unreachable and op 1010 is treated as an undefined op (c=0, zero=1).
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_mc_if.slave (in_valid/in_ready/a/b/op, out_valid/out_ready/c/zero/ovf)
//
// Parameters:
//   WIDTH : operand/result width, even and >= 8
//   SHW   : shift-amount width, taken from b[SHW-1:0]
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);

    if (WIDTH < 8 || (WIDTH % 2) != 0) begin : g_width_check
        $error("alu_mc: WIDTH must be even and at least 8");
    end

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpXor = 4'b0011;
    localparam logic [3:0] OpSll = 4'b0100;
    localparam logic [3:0] OpSrl = 4'b0101;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpLui = 4'b1000;
    localparam logic [3:0] OpSra = 4'b1001;
    localparam logic [3:0] OpMul = 4'b1010;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    // Single-cycle datapath, evaluated on the live inputs so the result is
    // captured at the accept edge.
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    assign shamt = bus.b[SHW-1:0];
    assign sum   = bus.a + bus.b;
    assign diff  = bus.a - bus.b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpSub: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpOr:    alu_res = bus.a | bus.b;
            OpAnd:   alu_res = bus.a & bus.b;
            OpXor:   alu_res = bus.a ^ bus.b;
            OpLui:   alu_res = bus.b << (WIDTH / 2);
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OpSll:   alu_res = bus.a << shamt;
            OpSrl:   alu_res = bus.a >> shamt;
            OpSra:   alu_res = $unsigned($signed(bus.a) >>> shamt);
            default: alu_res = '0;  // undefined codes (and MUL when disabled)
        endcase
    end

`ifdef ALU_MC_MUL_EN
    // Counter must reach WIDTH, hence the +1.
    localparam int unsigned CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_mul;

    assign is_mul = (bus.op == OpMul);
`endif

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`ifdef ALU_MC_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
`ifdef ALU_MC_MUL_EN
                    if (is_mul) begin
                        state_d  = StBusy;
                        acc_d    = '0;
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        cnt_d    = '0;
                    end else begin
                        state_d = StDone;
                        c_d     = alu_res;
                        zero_d  = (alu_res == '0);
                        ovf_d   = alu_ovf;
                    end
`else
                    state_d = StDone;
                    c_d     = alu_res;
                    zero_d  = (alu_res == '0);
                    ovf_d   = alu_ovf;
`endif
                end
            end
            StBusy: begin
`ifdef ALU_MC_MUL_EN
                // WIDTH step cycles, then one cycle to publish the product.
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    c_d     = acc_q;
                    zero_d  = (acc_q == '0);
                    ovf_d   = 1'b0;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            c_q     <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ALU_MC_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.c         = c_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;

endmodule
